// File: rtl/usb_line_packer.sv
// usb_line_packer: frames CIS pixel lines with a sync byte and a line counter,
// buffers them in a circular block-RAM FIFO and streams them out over a
// synchronous 245-FIFO write interface.
module usb_line_packer #(
    parameter int          ADDR_W    = 9,
    parameter logic [7:0]  SYNC_BYTE = 8'hFF
) (
    input  logic        USB_CLK,
    input  logic        RST,
    input  logic [7:0]  PIX_DATA,
    input  logic        PIX_VALID,
    input  logic        LINE_START,
    input  logic        USB_TXE_L,
    output logic [7:0]  USB_DATA,
    output logic        USB_WR_L,
    output logic        OVERFLOW,
    output logic [7:0]  LINE_CNT
);

    localparam int         DEPTH       = 1 << ADDR_W;
    localparam logic [7:0] MAX_PAYLOAD = SYNC_BYTE - 8'd1;

    typedef enum logic [1:0] {
        IDLE,
        HDR_SYNC,
        HDR_CNT
    } state_t;

    state_t          state;
    state_t          state_nxt;

    logic [7:0]      mem [DEPTH];
    logic [ADDR_W:0] wr_ptr;
    logic [ADDR_W:0] rd_ptr;

    logic            skid_valid;
    logic [7:0]      skid_data;
    logic            skid_valid_nxt;
    logic [7:0]      skid_data_nxt;
    logic            skid_drop;

    logic            enq;
    logic [7:0]      enq_data;
    logic            enq_accept;
    logic            enq_drop;

    logic            out_valid;
    logic            empty;
    logic            full;
    logic            load;
    logic            deq;

    // Payload bytes never carry the sync code.
    function automatic logic [7:0] clamp(input logic [7:0] b);
        return (b >= SYNC_BYTE) ? MAX_PAYLOAD : b;
    endfunction

    assign out_valid = ~USB_WR_L;
    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                       (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
    // Output register reloads when it is empty or its byte is being taken.
    assign load       = ~out_valid | ~USB_TXE_L;
    assign deq        = load & ~empty;
    // A dequeue in the same cycle frees the slot, so a full buffer still accepts.
    assign enq_accept = enq & (~full | deq);
    assign enq_drop   = enq & ~enq_accept;

    // Header FSM next state, write-side byte selection and skid handling.
    always_comb begin
        state_nxt      = state;
        enq            = 1'b0;
        enq_data       = '0;
        skid_valid_nxt = skid_valid;
        skid_data_nxt  = skid_data;
        skid_drop      = 1'b0;

        case (state)
            HDR_SYNC: begin
                enq       = 1'b1;
                enq_data  = SYNC_BYTE;
                state_nxt = HDR_CNT;
            end
            HDR_CNT: begin
                enq       = 1'b1;
                enq_data  = clamp(LINE_CNT);
                state_nxt = IDLE;
            end
            default: begin
                if (skid_valid) begin
                    // Drain the skid first; a pixel arriving now takes its place.
                    enq      = 1'b1;
                    enq_data = skid_data;
                    if (PIX_VALID) begin
                        skid_data_nxt = clamp(PIX_DATA);
                    end else begin
                        skid_valid_nxt = 1'b0;
                    end
                end else if (PIX_VALID) begin
                    enq      = 1'b1;
                    enq_data = clamp(PIX_DATA);
                end
            end
        endcase

        if (state != IDLE && PIX_VALID) begin
            if (skid_valid) begin
                skid_drop = 1'b1;
            end else begin
                skid_valid_nxt = 1'b1;
                skid_data_nxt  = clamp(PIX_DATA);
            end
        end

        if (LINE_START) begin
            state_nxt = HDR_SYNC;
        end
    end

    // Header FSM state register.
    always_ff @(posedge USB_CLK) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Line counter, skid register, write pointer and sticky overflow flag.
    always_ff @(posedge USB_CLK) begin
        if (RST) begin
            LINE_CNT   <= '0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
            wr_ptr     <= '0;
            OVERFLOW   <= 1'b0;
        end else begin
            if (LINE_START) begin
                LINE_CNT <= LINE_CNT + 8'd1;
            end
            skid_valid <= skid_valid_nxt;
            skid_data  <= skid_data_nxt;
            if (enq_accept) begin
                wr_ptr <= wr_ptr + (ADDR_W + 1)'(1);
            end
            if (enq_drop || skid_drop) begin
                OVERFLOW <= 1'b1;
            end
        end
    end

    // Buffer storage; contents need no reset because the pointers define validity.
    always_ff @(posedge USB_CLK) begin
        if (enq_accept) begin
            mem[wr_ptr[ADDR_W-1:0]] <= enq_data;
        end
    end

    // Registered buffer read straight into the output register; rd_ptr already
    // addresses the next byte, so back-to-back transfers need no bubble.
    always_ff @(posedge USB_CLK) begin
        if (RST) begin
            rd_ptr   <= '0;
            USB_WR_L <= 1'b1;
            USB_DATA <= '0;
        end else if (load) begin
            if (!empty) begin
                USB_DATA <= mem[rd_ptr[ADDR_W-1:0]];
                USB_WR_L <= 1'b0;
                rd_ptr   <= rd_ptr + (ADDR_W + 1)'(1);
            end else begin
                USB_WR_L <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_usb_line_packer.sv
// Directed bench for usb_line_packer: clamp table plus framing, back-pressure,
// overflow, early-pixel, counter-wrap and mid-stream reset sequences.
module tb_usb_line_packer;

    logic       USB_CLK = 1'b0;
    logic       RST = 1'b1;
    logic [7:0] PIX_DATA = '0;
    logic       PIX_VALID = 1'b0;
    logic       LINE_START = 1'b0;
    logic       USB_TXE_L = 1'b0;
    logic [7:0] USB_DATA;
    logic       USB_WR_L;
    logic       OVERFLOW;
    logic [7:0] LINE_CNT;

    int errors = 0;
    int checks = 0;

    logic [7:0] got [$];

    typedef struct {
        logic [7:0] pix;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs [8];

    always #5 USB_CLK = ~USB_CLK;

    usb_line_packer #(
        .ADDR_W    (9),
        .SYNC_BYTE (8'hFF)
    ) dut (
        .USB_CLK    (USB_CLK),
        .RST        (RST),
        .PIX_DATA   (PIX_DATA),
        .PIX_VALID  (PIX_VALID),
        .LINE_START (LINE_START),
        .USB_TXE_L  (USB_TXE_L),
        .USB_DATA   (USB_DATA),
        .USB_WR_L   (USB_WR_L),
        .OVERFLOW   (OVERFLOW),
        .LINE_CNT   (LINE_CNT)
    );

    // Record every byte that transfers on the coming rising edge.
    always @(negedge USB_CLK) begin
        if (!RST && !USB_WR_L && !USB_TXE_L) got.push_back(USB_DATA);
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge USB_CLK);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        RST        = 1'b1;
        PIX_VALID  = 1'b0;
        LINE_START = 1'b0;
        PIX_DATA   = '0;
        tick();
        tick();
        RST = 1'b0;
    endtask

    task automatic wait_got(input int n, input int budget, input string name);
        int c = 0;
        while (got.size() < n && c < budget) begin
            tick();
            c++;
        end
        check(name, got.size(), n);
    endtask

    function automatic logic [7:0] got_at(input int i);
        if (i < got.size()) return got[i];
        return 8'hxx;
    endfunction

    function automatic logic [7:0] clampb(input logic [7:0] b);
        return (b == 8'hFF) ? 8'hFE : b;
    endfunction

    initial begin
        logic [7:0] hdr_exp [6];
        logic [7:0] hdr_pix [4];
        logic [7:0] snap;
        int         bad;

        vecs[0] = '{8'h00, 8'h00};
        vecs[1] = '{8'h01, 8'h01};
        vecs[2] = '{8'h7F, 8'h7F};
        vecs[3] = '{8'h80, 8'h80};
        vecs[4] = '{8'hAA, 8'hAA};
        vecs[5] = '{8'hFD, 8'hFD};
        vecs[6] = '{8'hFE, 8'hFE};
        vecs[7] = '{8'hFF, 8'hFE};

        hdr_exp = '{8'hFF, 8'h01, 8'h10, 8'h20, 8'hFE, 8'h64};
        hdr_pix = '{8'h10, 8'h20, 8'hFF, 8'h64};

        // Reset values
        USB_TXE_L = 1'b0;
        do_reset();
        check("rst_wr_l", USB_WR_L, 1);
        check("rst_data", USB_DATA, 8'h00);
        check("rst_ovf", OVERFLOW, 0);
        check("rst_line_cnt", LINE_CNT, 0);

        // Framed line, cycle-exact: header at N+3/N+4, pixels follow with no gap
        LINE_START = 1'b1;
        tick();
        LINE_START = 1'b0;
        check("line_cnt_1", LINE_CNT, 1);
        tick();
        check("hdr_not_yet", USB_WR_L, 1);
        tick();
        for (int i = 0; i < 6; i++) begin
            check($sformatf("line1_wrl_%0d", i), USB_WR_L, 0);
            check($sformatf("line1_data_%0d", i), USB_DATA, hdr_exp[i]);
            if (i < 4) begin
                PIX_VALID = 1'b1;
                PIX_DATA  = hdr_pix[i];
            end else begin
                PIX_VALID = 1'b0;
            end
            tick();
        end
        check("line1_done", USB_WR_L, 1);
        check("line1_ovf", OVERFLOW, 0);

        // Clamp table: enqueue, load one cycle later, gone after one transfer
        for (int v = 0; v < 8; v++) begin
            PIX_VALID = 1'b1;
            PIX_DATA  = vecs[v].pix;
            tick();
            PIX_VALID = 1'b0;
            check($sformatf("vec%0d_latency", v), USB_WR_L, 1);
            tick();
            check($sformatf("vec%0d_wrl", v), USB_WR_L, 0);
            check($sformatf("vec%0d_data", v), USB_DATA, vecs[v].exp);
            tick();
            check($sformatf("vec%0d_single", v), USB_WR_L, 1);
        end

        // Back-pressure: 100 cycles of TXE high mid-stream
        got.delete();
        snap = '0;
        bad  = 0;
        for (int c = 0; c < 106; c++) begin
            if (c < 20) begin
                PIX_VALID = 1'b1;
                PIX_DATA  = 8'h30 + 8'(c);
            end else begin
                PIX_VALID = 1'b0;
            end
            if (c == 6) begin
                USB_TXE_L = 1'b1;
                snap      = USB_DATA;
                check("bp_wrl_at_hold", USB_WR_L, 0);
            end
            tick();
            if (c >= 6 && (USB_WR_L !== 1'b0 || USB_DATA !== snap)) bad++;
        end
        check("bp_frozen_cycles_bad", bad, 0);
        USB_TXE_L = 1'b0;
        wait_got(20, 100, "bp_count");
        repeat (5) tick();
        check("bp_no_dup", got.size(), 20);
        bad = 0;
        for (int i = 0; i < 20; i++) if (got_at(i) !== 8'h30 + 8'(i)) bad++;
        check("bp_order_bad", bad, 0);

        // Fill to overflow with TXE high: out reg + 512 buffered, rest dropped
        do_reset();
        USB_TXE_L = 1'b1;
        got.delete();
        for (int k = 0; k < 520; k++) begin
            PIX_VALID = 1'b1;
            PIX_DATA  = 8'(k);
            tick();
            if (k == 512) check("ovf_at_full", OVERFLOW, 0);
            if (k == 513) check("ovf_after_drop", OVERFLOW, 1);
        end
        // Write while full with a simultaneous dequeue is accepted
        USB_TXE_L = 1'b0;
        PIX_DATA  = 8'h77;
        tick();
        PIX_VALID = 1'b0;
        wait_got(514, 700, "ovf_drain_count");
        repeat (5) tick();
        check("ovf_drain_no_extra", got.size(), 514);
        bad = 0;
        for (int i = 0; i < 514; i++) begin
            if (got_at(i) !== ((i < 513) ? clampb(8'(i)) : 8'h77)) bad++;
        end
        check("ovf_drain_bad", bad, 0);
        check("ovf_sticky", OVERFLOW, 1);

        // Reset while bytes are buffered and WR_L is low
        USB_TXE_L  = 1'b1;
        LINE_START = 1'b1;
        tick();
        LINE_START = 1'b0;
        repeat (3) tick();
        for (int i = 0; i < 48; i++) begin
            PIX_VALID = 1'b1;
            PIX_DATA  = 8'h40 + 8'(i);
            tick();
        end
        PIX_VALID = 1'b0;
        tick();
        check("midrst_pre_wrl", USB_WR_L, 0);
        check("midrst_pre_cnt", LINE_CNT, 1);
        RST = 1'b1;
        tick();
        check("midrst_wrl", USB_WR_L, 1);
        check("midrst_ovf", OVERFLOW, 0);
        check("midrst_cnt", LINE_CNT, 0);
        RST       = 1'b0;
        USB_TXE_L = 1'b0;
        got.delete();
        repeat (20) tick();
        check("midrst_no_stale", got.size(), 0);
        check("midrst_idle_wrl", USB_WR_L, 1);

        // Pixels one and two cycles after LINE_START: first skidded, second dropped
        do_reset();
        got.delete();
        LINE_START = 1'b1;
        tick();
        LINE_START = 1'b0;
        PIX_VALID  = 1'b1;
        PIX_DATA   = 8'h42;
        tick();
        check("skid_no_ovf", OVERFLOW, 0);
        PIX_DATA = 8'h43;
        tick();
        PIX_VALID = 1'b0;
        tick();
        check("skid_drop_ovf", OVERFLOW, 1);
        wait_got(3, 20, "skid_count");
        repeat (4) tick();
        check("skid_no_extra", got.size(), 3);
        check("skid_b0", got_at(0), 8'hFF);
        check("skid_b1", got_at(1), 8'h01);
        check("skid_b2", got_at(2), 8'h42);

        // 300 lines: counter wraps, count byte clamps FF to FE
        do_reset();
        got.delete();
        for (int l = 1; l <= 300; l++) begin
            LINE_START = 1'b1;
            tick();
            LINE_START = 1'b0;
            tick();
            tick();
        end
        check("wrap_line_cnt", LINE_CNT, 44);
        wait_got(600, 50, "wrap_count");
        bad = 0;
        for (int l = 1; l <= 300; l++) begin
            if (got_at(2 * (l - 1)) !== 8'hFF) bad++;
            if (got_at(2 * (l - 1) + 1) !== clampb(8'(l))) bad++;
        end
        check("wrap_seq_bad", bad, 0);
        check("wrap_cnt254", got_at(2 * 253 + 1), 8'hFE);
        check("wrap_cnt255", got_at(2 * 254 + 1), 8'hFE);
        check("wrap_cnt256", got_at(2 * 255 + 1), 8'h00);
        check("wrap_cnt300", got_at(2 * 299 + 1), 8'h2C);
        check("wrap_no_ovf", OVERFLOW, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
